fir_filter_param: RTL
=====================

// Module: fir_filter_param
// PURPOSE
//  Parametrised direct-form FIR filter: TAPS coefficients, signed fixed-point
//  samples of WL bits with WF fractional bits. Coefficients are loaded serially
//  via a strobe; samples enter under a valid handshake. Output is a rounded,
//  saturated WL-bit result with a registered valid and a sticky overflow flag.
//  Sits between the sample source and downstream DSP stages, one sample/cycle.
// PARAMETERS
//  WL    8  sample, coefficient and output word length (signed, two's complement)
//  WF    6  fractional bits of samples, coefficients and output (Q(WL-WF).WF)
//  TAPS  3  number of taps (>=2)
// PORTS
//  clk        in   1   clock, rising-edge
//  reset_n    in   1   asynchronous, active-low reset
//  coef_load  in   1   strobe: coef_in is a coefficient this cycle
//  coef_in    in   WL  coefficient word
//  coef_ready out  1   all TAPS coefficients loaded; filter in RUN
//  x_valid    in   1   x carries a sample this cycle
//  x          in   WL  input sample
//  x_ready    out  1   sample accepted when x_valid&x_ready (=coef_ready)
//  y          out  WL  filter output
//  y_valid    out  1   one-cycle pulse: y holds a new result
//  ovf        out  1   sticky: a result was saturated since reset/ovf_clr
//  ovf_clr    in   1   synchronous clear of ovf
// BEHAVIOUR
//  Reset (reset_n=0, async): state LOAD, coef count 0, coefficients, delay line,
//   pipeline, y, y_valid, ovf, coef_ready all 0.
//  States: LOAD (coef_ready=0) / RUN (coef_ready=1).
//  LOAD: each coef_load shifts coef_in into coefficient chain, count++. On the
//   edge taking the TAPS-th coefficient -> RUN. First-loaded word becomes h[0]
//   (multiplies newest sample), last-loaded becomes h[TAPS-1]. x_valid ignored.
//  RUN: x_valid accepted: delay line shifts, x -> d[0], d[k] -> d[k+1].
//   coef_load in RUN -> LOAD: count=1 (this word is first coefficient), delay
//   line and pipeline cleared, any pending y_valid suppressed. Simultaneous
//   coef_load and x_valid: coef_load wins, sample dropped (x_ready already 0? no:
//   x_ready is 1 that cycle, but sample is discarded by design).
//  Datapath: products p[k]=h[k]*d[k], full 2*WL bits, 2*WF frac; registered.
//   Sum of TAPS products in 2*WL+clog2(TAPS) bits, no intermediate overflow.
//   Round half-up: add 2^(WF-1), arithmetic shift right WF.
//   Saturate to [-2^(WL-1), 2^(WL-1)-1]; on saturation set ovf.
//  Latency: sample accepted at edge E -> y, y_valid updated at edge E+2.
//   y_valid high exactly one cycle per accepted sample; y holds between results.
//   Back-to-back samples give back-to-back results (throughput 1/cycle).
//  ovf: set on any saturating result; ovf_clr clears; set wins if same cycle.
//  Coefficient chain never changes in RUN except via a new LOAD sequence.
// TESTING (WL=8, WF=6, TAPS=3; 1.0=0x40)
//  Load 0x40,0x20,0x10; then x=0x40,0,0,0 one per cycle -> y=0x40,0x20,0x10,0x00,
//   each y_valid 2 edges after acceptance; coef_ready rises after 3rd load.
//  x_valid during LOAD (only 2 coefs loaded) -> x_ready=0, no y_valid, y stays 0.
//  Coefs 0x7F,0x7F,0x7F, x=0x7F steady -> y=0x7F, ovf=1; x=0x80 steady -> y=0x80;
//   ovf_clr pulse with no further saturation -> ovf=0.
//  Rounding: coefs 0x20,0,0, x=0x01 -> y=0x01; x=0xFF (-1 LSB) -> y=0x00.
//  Mid-stream coef_load with simultaneous x_valid -> sample dropped, coef_ready=0
//   next cycle, no y_valid for in-flight samples; after 2 more loads RUN resumes
//   with zeroed history (impulse gives new taps only).
//  reset_n low mid-stream (async, between edges) -> all outputs 0 immediately;
//   after release, coef_ready=0 until 3 new coefficients loaded.

Source files
------------

// File: rtl/fir_filter_param.sv
// Direct-form FIR filter with serially loaded coefficients, a registered product
// stage, half-up rounding and saturation to a WL-bit output with sticky overflow.

module fir_filter_param_tap #(
   parameter int WL = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic [WL-1:0]     h,
   input  logic [WL-1:0]     d,
   output logic [2*WL-1:0]   p
);
   logic signed [2*WL-1:0] he, de;

   assign he = {{WL{h[WL-1]}}, h};
   assign de = {{WL{d[WL-1]}}, d};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  p <= '0;
      else if (clr)  p <= '0;
      else           p <= he * de;
   end
endmodule

module fir_filter_param #(
   parameter int WL   = 8,
   parameter int WF   = 6,
   parameter int TAPS = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          coef_load,
   input  logic [WL-1:0] coef_in,
   output logic          coef_ready,
   input  logic          x_valid,
   input  logic [WL-1:0] x,
   output logic          x_ready,
   output logic [WL-1:0] y,
   output logic          y_valid,
   output logic          ovf,
   input  logic          ovf_clr
);
   localparam int CW     = $clog2(TAPS + 1);
   localparam int SW     = 2*WL + $clog2(TAPS);
   localparam int STAGES = 2;
   localparam logic signed [SW-1:0] RND  = SW'(2**(WF-1));
   localparam logic signed [SW-1:0] MAXV = SW'(2**(WL-1) - 1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   typedef enum logic {LOAD, RUN} state_t;

   state_t                     state;
   logic [CW-1:0]              cnt;
   logic [TAPS-1:0][WL-1:0]    h;
   logic [TAPS-1:0][WL-1:0]    d;
   logic [TAPS-1:0][2*WL-1:0]  p;
   logic [STAGES:0]            vld_pipe;
   logic                       flush, accept;
   logic signed [SW-1:0]       acc, rnd;
   logic                       sat_hi, sat_lo;
   logic [WL-1:0]              y_next;

   // A coefficient strobe while running restarts loading and discards any
   // sample presented in the same cycle.
   assign flush   = coef_ready & coef_load;
   assign accept  = coef_ready & x_valid & ~coef_load;
   assign x_ready = coef_ready;
   assign y_valid = vld_pipe[STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= LOAD;
         coef_ready <= 1'b0;
         cnt        <= '0;
         h          <= '0;
      end else if (coef_load) begin
         // First word loaded drifts down to h[0] after TAPS loads.
         h <= {coef_in, h[TAPS-1:1]};
         if (state == RUN) begin
            state      <= LOAD;
            coef_ready <= 1'b0;
            cnt        <= CW'(1);
         end else if (cnt == CW'(TAPS-1)) begin
            state      <= RUN;
            coef_ready <= 1'b1;
            cnt        <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d        <= '0;
         vld_pipe <= '0;
      end else begin
         if (flush)       d <= '0;
         else if (accept) d <= {d[TAPS-2:0], x};
         vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1:0], accept};
      end
   end

   genvar k;
   generate
      for (k = 0; k < TAPS; k++) begin : g_tap
         fir_filter_param_tap #(.WL(WL)) u_tap (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (flush),
            .h       (h[k]),
            .d       (d[k]),
            .p       (p[k])
         );
      end
   endgenerate

   always_comb begin
      acc = '0;
      for (int i = 0; i < TAPS; i++)
         acc = acc + $signed({{(SW-2*WL){p[i][2*WL-1]}}, p[i]});
      rnd    = (acc + RND) >>> WF;
      sat_hi = rnd > MAXV;
      sat_lo = rnd < MINV;
      y_next = sat_hi ? MAXV[WL-1:0] : (sat_lo ? MINV[WL-1:0] : rnd[WL-1:0]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y   <= '0;
         ovf <= 1'b0;
      end else begin
         if (vld_pipe[STAGES-1] && !flush) y <= y_next;
         ovf <= (ovf & ~ovf_clr) | (vld_pipe[STAGES-1] & ~flush & (sat_hi | sat_lo));
      end
   end
endmodule
